// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register-index width, the hard-wired $0 index, the HI/LO FSM states and a source-match helper.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // True when the ID instruction reads register r; $0 never matches.
    function automatic logic src_hit(
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic             use_rt,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] r
    );
        return (r != REG_ZERO) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// The master side drives the ID/EX/MEM fields; the slave side returns stall/flush and HI/LO status.
interface pipe_hazard_ctrl_if;

    logic [pipe_pkg::REG_W-1:0] rs_id;
    logic [pipe_pkg::REG_W-1:0] rt_id;
    logic                       use_rs_id;
    logic                       use_rt_id;
    logic                       branch_id;
    logic                       taken_id;
    logic                       hilo_use_id;
    logic [pipe_pkg::REG_W-1:0] wreg_ex;
    logic                       regwrite_ex;
    logic                       memread_ex;
    logic [pipe_pkg::REG_W-1:0] wreg_mem;
    logic                       memread_mem;
    logic                       md_start_ex;
    logic                       md_is_div;
    logic                       stall_pc;
    logic                       stall_if_id;
    logic                       flush_if_id;
    logic                       flush_id_ex;
    logic                       md_busy;
    logic                       md_done;

    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, branch_id, taken_id, hilo_use_id,
               wreg_ex, regwrite_ex, memread_ex, wreg_mem, memread_mem,
               md_start_ex, md_is_div,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex, md_busy, md_done
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, branch_id, taken_id, hilo_use_id,
               wreg_ex, regwrite_ex, memread_ex, wreg_mem, memread_mem,
               md_start_ex, md_is_div,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex, md_busy, md_done
    );

endinterface

// File: rtl/md_seq.sv
// Multiply/divide occupancy sequencer: IDLE/BUSY FSM with a latency down-counter.
// busy covers the full unit latency after the start edge; done marks the last busy cycle.
module md_seq
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    // done is registered one cycle ahead: it rises as the counter steps onto zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        cnt  <= cnt - CNT_ONE;
                        done <= (cnt == CNT_ONE);
                    end
                end
            endcase
        end
    end

    // A second start while the unit is occupied is dropped; flag it in simulation.
    always_ff @(posedge clk) begin
        if (rst && (state == BUSY)) begin
            assert (!start) else $warning("md_seq: md_start_ex ignored while unit busy");
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Combines load-use, branch-operand and HI/LO hazards into one hold and squashes wrong-path fetches.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    logic load_use;
    logic br_ex;
    logic br_mem;
    logic hilo_wait;
    logic hold;
    logic hit_ex;
    logic hit_mem;

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.md_start_ex),
        .is_div (bus.md_is_div),
        .busy   (bus.md_busy),
        .done   (bus.md_done)
    );

    assign hit_ex  = src_hit(bus.use_rs_id, bus.rs_id, bus.use_rt_id, bus.rt_id, bus.wreg_ex);
    assign hit_mem = src_hit(bus.use_rs_id, bus.rs_id, bus.use_rt_id, bus.rt_id, bus.wreg_mem);

    // The start cycle counts as busy so an MFLO right behind a MULT already waits.
    assign load_use  = bus.memread_ex && hit_ex;
    assign br_ex     = bus.branch_id && bus.regwrite_ex && hit_ex;
    assign br_mem    = bus.branch_id && bus.memread_mem && hit_mem;
    assign hilo_wait = bus.hilo_use_id && (bus.md_busy || bus.md_start_ex);
    assign hold      = rst && (load_use || br_ex || br_mem || hilo_wait);

    assign bus.stall_pc    = hold;
    assign bus.stall_if_id = hold;
    assign bus.flush_id_ex = hold;
    assign bus.flush_if_id = rst && bus.taken_id && !hold;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-count model of the HI/LO unit and the hazard rules.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rem   = 0;   // model: busy cycles still to go, including the current one

    function automatic logic [5:0] outs();
        return {bus.stall_pc, bus.stall_if_id, bus.flush_id_ex,
                bus.flush_if_id, bus.md_busy, bus.md_done};
    endfunction

    function automatic bit m_reads(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (bus.use_rs_id && bus.rs_id == r) || (bus.use_rt_id && bus.rt_id == r);
    endfunction

    function automatic logic [5:0] model_outs();
        bit h;
        if (!rst) return 6'b0;
        h = (bus.memread_ex && m_reads(bus.wreg_ex))
          || (bus.branch_id && bus.regwrite_ex && m_reads(bus.wreg_ex))
          || (bus.branch_id && bus.memread_mem && m_reads(bus.wreg_mem))
          || (bus.hilo_use_id && (rem > 0 || bus.md_start_ex));
        return {h, h, h, bus.taken_id && !h, rem > 0, rem == 1};
    endfunction

    task automatic idle_inputs();
        bus.rs_id = '0; bus.rt_id = '0; bus.use_rs_id = 0; bus.use_rt_id = 0;
        bus.branch_id = 0; bus.taken_id = 0; bus.hilo_use_id = 0;
        bus.wreg_ex = '0; bus.regwrite_ex = 0; bus.memread_ex = 0;
        bus.wreg_mem = '0; bus.memread_mem = 0;
        bus.md_start_ex = 0; bus.md_is_div = 0;
    endtask

    // Advance one clock and update the unit model; returns at posedge + 1.
    task automatic tick();
        @(posedge clk);
        if (!rst) rem = 0;
        else if (rem > 0) rem--;
        else if (bus.md_start_ex) rem = bus.md_is_div ? DIV_N : MULT_N;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rem = 0;
        idle_inputs();
        #2;
        n_cmp++;
        if (outs() !== 6'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want %b", outs(), 6'b0);
        end
        @(negedge clk); rst = 1'b1;
        tick();
        n_cmp++;
        if (outs() !== 6'b0) begin
            n_bad++; $display("FAIL post_reset_idle: got %b want %b", outs(), 6'b0);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        bus.memread_ex = 1; bus.regwrite_ex = 1; bus.wreg_ex = 5'd2;
        bus.rs_id = 5'd2; bus.use_rs_id = 1; #1;
        n_cmp++;
        if (outs() !== 6'b111000) begin
            n_bad++; $display("FAIL load_use_rs: got %b want %b", outs(), 6'b111000);
        end
        tick();
        // bubble now in EX, load in MEM; a non-branch ADD proceeds
        bus.memread_ex = 0; bus.regwrite_ex = 0; bus.wreg_ex = '0;
        bus.memread_mem = 1; bus.wreg_mem = 5'd2; #1;
        n_cmp++;
        if (outs() !== 6'b000000) begin
            n_bad++; $display("FAIL load_use_release: got %b want %b", outs(), 6'b0);
        end
        tick();
        idle_inputs();
        bus.memread_ex = 1; bus.regwrite_ex = 1; bus.wreg_ex = 5'd0;
        bus.rs_id = 5'd0; bus.use_rs_id = 1; #1;
        n_cmp++;
        if (outs() !== 6'b000000) begin
            n_bad++; $display("FAIL load_use_r0: got %b want %b", outs(), 6'b0);
        end
        tick();
        idle_inputs();
        bus.memread_ex = 1; bus.wreg_ex = 5'd5; bus.rt_id = 5'd5; bus.use_rt_id = 1; #1;
        n_cmp++;
        if (outs() !== 6'b111000) begin
            n_bad++; $display("FAIL load_use_rt: got %b want %b", outs(), 6'b111000);
        end
        bus.use_rt_id = 0; #1;
        n_cmp++;
        if (outs() !== 6'b000000) begin
            n_bad++; $display("FAIL load_use_rt_unused: got %b want %b", outs(), 6'b0);
        end
        tick();
    endtask

    task automatic test_branch();
        idle_inputs();
        bus.branch_id = 1; bus.taken_id = 1; bus.rs_id = 5'd3; bus.use_rs_id = 1;
        bus.memread_ex = 1; bus.regwrite_ex = 1; bus.wreg_ex = 5'd3; #1;
        n_cmp++;
        if (outs() !== 6'b111000) begin
            n_bad++; $display("FAIL branch_bubble1: got %b want %b", outs(), 6'b111000);
        end
        tick();
        bus.memread_ex = 0; bus.regwrite_ex = 0; bus.wreg_ex = '0;
        bus.memread_mem = 1; bus.wreg_mem = 5'd3; #1;
        n_cmp++;
        if (outs() !== 6'b111000) begin
            n_bad++; $display("FAIL branch_bubble2: got %b want %b", outs(), 6'b111000);
        end
        tick();
        bus.memread_mem = 0; bus.wreg_mem = '0; #1;
        n_cmp++;
        if (outs() !== 6'b000100) begin
            n_bad++; $display("FAIL branch_resolve: got %b want %b", outs(), 6'b000100);
        end
        tick();
        // ALU result in EX (not a load) also costs one branch bubble
        idle_inputs();
        bus.branch_id = 1; bus.rt_id = 5'd7; bus.use_rt_id = 1;
        bus.regwrite_ex = 1; bus.wreg_ex = 5'd7; #1;
        n_cmp++;
        if (outs() !== 6'b111000) begin
            n_bad++; $display("FAIL branch_alu_ex: got %b want %b", outs(), 6'b111000);
        end
        tick();
    endtask

    task automatic test_taken();
        idle_inputs();
        bus.taken_id = 1; #1;
        n_cmp++;
        if (outs() !== 6'b000100) begin
            n_bad++; $display("FAIL taken_plain: got %b want %b", outs(), 6'b000100);
        end
        bus.memread_ex = 1; bus.wreg_ex = 5'd9; bus.rs_id = 5'd9; bus.use_rs_id = 1; #1;
        n_cmp++;
        if (outs() !== 6'b111000) begin
            n_bad++; $display("FAIL taken_with_load_use: got %b want %b", outs(), 6'b111000);
        end
        tick();
    endtask

    task automatic test_mult();
        logic [5:0] exp;
        bit s, b, d;
        idle_inputs();
        bus.hilo_use_id = 1; bus.md_start_ex = 1; bus.md_is_div = 0;
        for (int c = 0; c <= 6; c++) begin
            #1;
            s = (c <= MULT_N); b = (c >= 1 && c <= MULT_N); d = (c == MULT_N);
            exp = {s, s, s, 1'b0, b, d};
            n_cmp++;
            if (outs() !== exp) begin
                n_bad++; $display("FAIL mult_mflo c%0d: got %b want %b", c, outs(), exp);
            end
            tick();
            bus.md_start_ex = 0;
        end
        idle_inputs();
        bus.md_start_ex = 1; bus.rs_id = 5'd4; bus.use_rs_id = 1;
        for (int c = 0; c <= 5; c++) begin
            #1;
            b = (c >= 1 && c <= MULT_N); d = (c == MULT_N);
            exp = {3'b000, 1'b0, b, d};
            n_cmp++;
            if (outs() !== exp) begin
                n_bad++; $display("FAIL mult_add c%0d: got %b want %b", c, outs(), exp);
            end
            tick();
            bus.md_start_ex = 0;
        end
    endtask

    task automatic test_div();
        int done_at;
        logic [1:0] exp;
        idle_inputs();
        done_at = -1;
        bus.md_start_ex = 1; bus.md_is_div = 1;
        for (int c = 0; c <= DIV_N + 3; c++) begin
            bus.md_start_ex = (c == 0 || c == 10);
            bus.md_is_div   = (c == 0);
            #1;
            exp = {c >= 1 && c <= DIV_N, c == DIV_N};
            if (bus.md_done === 1'b1 && done_at < 0) done_at = c;
            n_cmp++;
            if ({bus.md_busy, bus.md_done} !== exp) begin
                n_bad++; $display("FAIL div_busy_done c%0d: got %b want %b", c, {bus.md_busy, bus.md_done}, exp);
            end
            tick();
        end
        n_cmp++;
        if (done_at != DIV_N) begin
            n_bad++; $display("FAIL div_latency: got %0d want %0d", done_at, DIV_N);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int seen;
        idle_inputs();
        bus.md_start_ex = 1; bus.md_is_div = 1;
        tick();
        bus.md_start_ex = 0; bus.md_is_div = 0;
        for (int c = 1; c < 15; c++) tick();
        #1; rst = 1'b0; rem = 0; #1;
        n_cmp++;
        if (outs() !== 6'b0) begin
            n_bad++; $display("FAIL reset_mid_busy: got %b want %b", outs(), 6'b0);
        end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        for (int c = 0; c < DIV_N + 4; c++) begin
            tick();
            if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", seen);
        end
        // a fresh MULT must see a clean IDLE and finish on time
        bus.md_start_ex = 1;
        tick();
        bus.md_start_ex = 0;
        seen = -1;
        for (int c = 1; c <= MULT_N + 2; c++) begin
            if (bus.md_done === 1'b1 && seen < 0) seen = c;
            tick();
        end
        n_cmp++;
        if (seen != MULT_N) begin
            n_bad++; $display("FAIL reset_mid_restart: got done at %0d want %0d", seen, MULT_N);
        end
    endtask

    task automatic test_random();
        logic [5:0] exp;
        for (int i = 0; i < 400; i++) begin
            bus.rs_id       = 5'($urandom_range(0, 3));
            bus.rt_id       = 5'($urandom_range(0, 3));
            bus.use_rs_id   = 1'($urandom);
            bus.use_rt_id   = 1'($urandom);
            bus.branch_id   = 1'($urandom);
            bus.taken_id    = 1'($urandom);
            bus.hilo_use_id = ($urandom_range(0, 3) == 0);
            bus.wreg_ex     = 5'($urandom_range(0, 3));
            bus.regwrite_ex = 1'($urandom);
            bus.memread_ex  = 1'($urandom);
            bus.wreg_mem    = 5'($urandom_range(0, 3));
            bus.memread_mem = 1'($urandom);
            bus.md_start_ex = (rem == 0) && ($urandom_range(0, 7) == 0);
            bus.md_is_div   = ($urandom_range(0, 3) == 0);
            #1;
            exp = model_outs();
            n_cmp++;
            if (outs() !== exp) begin
                n_bad++; $display("FAIL random_cycle%0d: got %b want %b", i, outs(), exp);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_taken();
        test_mult();
        test_div();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the stall/flush inputs of the IF/ID and ID/EX pipeline registers and the PC hold.
- Detects load-use and branch-operand hazards, squashes the wrong-path fetch on taken branches/jumps (resolved in ID), and sequences the multi-cycle HI/LO multiply/divide unit.
- ID-stage instructions that touch HI/LO wait until the unit finishes; all other instructions proceed.

Parameters:
- MULT_CYCLES, 4, total EX-unit latency of MULT/MULTU in cycles (>=2)
- DIV_CYCLES, 32, total latency of DIV/DIVU in cycles (>=2)
- CNT_W, 6, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- rs_id  in  5  rs field of instruction in ID
- rt_id  in  5  rt field of instruction in ID
- use_rs_id  in  1  ID instruction reads rs
- use_rt_id  in  1  ID instruction reads rt
- branch_id  in  1  ID instruction is a conditional branch (compares in ID)
- taken_id  in  1  branch/jump in ID redirects PC (valid only when not stalled)
- hilo_use_id  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT(U)/DIV(U)
- wreg_ex  in  5  destination register of EX instruction
- regwrite_ex  in  1  EX instruction writes the register file
- memread_ex  in  1  EX instruction is a load
- wreg_mem  in  5  destination register of MEM instruction
- memread_mem  in  1  MEM instruction is a load
- md_start_ex  in  1  MULT/DIV entered EX this cycle (single-cycle pulse)
- md_is_div  in  1  qualifies md_start_ex: 1 = divide
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- flush_if_id  out  1  clear IF/ID to NOP
- flush_id_ex  out  1  clear ID/EX to NOP (bubble)
- md_busy  out  1  multiply/divide unit occupied
- md_done  out  1  one-cycle pulse on the last busy cycle; HI/LO write enable

Behaviour:
- Matches are qualified by a nonzero register number; register $0 never causes a hazard.
- Hazard terms (combinational):
  - src_hit(r) = (use_rs_id && rs_id==r) || (use_rt_id && rt_id==r)
  - load_use = memread_ex && src_hit(wreg_ex)
  - br_ex = branch_id && regwrite_ex && src_hit(wreg_ex), giving one bubble
  - br_mem = branch_id && memread_mem && src_hit(wreg_mem), giving a second bubble for a branch behind a load
  - hilo_wait = hilo_use_id && md_busy
- hold = load_use || br_ex || br_mem || hilo_wait
- Outputs:
  - stall_pc = stall_if_id = flush_id_ex = hold
  - flush_if_id = taken_id && !hold; a stalled branch never flushes.
- State machine, registered, two states:
  - IDLE -> BUSY on md_start_ex. The counter loads (md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: the counter decrements each cycle. When it is 0, md_done=1 and the next state is IDLE.
  - md_busy=1 in BUSY and is 0 in IDLE. md_busy therefore rises the cycle after md_start_ex.
  - In the md_start_ex cycle, hilo_wait is forced on via md_start_ex && hilo_use_id, so a back-to-back MFLO stalls.
  - md_start_ex while in BUSY is a protocol error: ignore it, do not restart, and flag it with a simulation assertion.
- Latency, MULT: md_done is asserted exactly MULT_CYCLES cycles after the md_start_ex edge. A waiting MFLO leaves ID on the cycle after md_done.
- Reset: asynchronous on rst=0.
  - State = IDLE, counter = 0, md_busy = md_done = 0.
  - All stall/flush outputs are 0 while reset is held, with inputs assumed idle.
  - Reset mid-BUSY aborts the operation and produces no md_done.
- Simultaneous events:
  - hold has priority over flush_if_id.
  - load_use and br_ex together produce one bubble per cycle; the hazard terms re-evaluate every cycle.

Decomposition:
- Shared package pipe_pkg:
  - state enum {IDLE, BUSY}
  - register-index width constant (5)
  - $0 constant
- One sub-module, md_seq, is natural: the IDLE/BUSY FSM plus the down-counter (md_start_ex/md_is_div in; md_busy/md_done out).
- Hazard equations stay in the top level.

Test Plan:
- LW $2 in EX (memread_ex=1, wreg_ex=2), ADD in ID with rs_id=2, use_rs_id=1 -> stall_pc=stall_if_id=flush_id_ex=1 for exactly 1 cycle. Same with wreg_ex=0 -> no stall.
- BEQ in ID using $3, LW $3 in EX -> bubble in cycle 1 (br_ex). Next cycle LW is in MEM -> bubble in cycle 2 (br_mem). Cycle 3: taken_id=1 -> flush_if_id=1, no stall.
- taken_id=1 with no hazards -> flush_if_id=1 for one cycle, stall signals 0. taken_id=1 together with load_use -> flush_if_id=0.
- md_start_ex, md_is_div=0 at cycle 0 -> md_busy=1 for cycles 1-4, md_done=1 at cycle 4. An MFLO in ID from cycle 0 stalls cycles 0-4 and is released at cycle 5. An unrelated ADD in ID is not stalled.
- DIV start -> md_done exactly 32 cycles later. A second md_start_ex at busy cycle 10 is ignored and done stays at 32.
- rst=0 at busy cycle 15 of a DIV -> md_busy=0 and all outputs 0 immediately. After release, no md_done and the FSM is IDLE.
